// File: rtl/counter_pkg.sv
// Shared counter constants: width and all-ones reset value reused by the
// free-running counters in this codebase.
package counter_pkg;

  localparam int              CNT_WIDTH = 7;
  localparam logic [6:0]      CNT_RESET = 7'h7F;

endpackage : counter_pkg

// File: rtl/down_counter_7bit.sv
// Free-running WIDTH-bit binary down counter: async reset to all-ones,
// decrements by one every rising edge and wraps from 0 back to all-ones.
module down_counter_7bit
  import counter_pkg::*;
#(
  parameter int               WIDTH     = CNT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = CNT_RESET
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  // The wrap from 0 to all-ones relies on the reset value being all-ones.
  generate
    if (RESET_VAL != ALL_ONES) begin : g_bad_reset_val
      $error("down_counter_7bit: RESET_VAL must equal 2**WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_r;

  // Count state: async reset to all-ones, otherwise modulo-2**WIDTH decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= RESET_VAL;
    end else begin
      cnt_r <= cnt_r - ONE;
    end
  end

  assign q = cnt_r;

endmodule : down_counter_7bit

// File: tb/tb_down_counter_7bit.sv
// Self-checking bench for down_counter_7bit: edge-count model plus
// directed, hand-computed checkpoints.
`timescale 1ns/1ps
module tb_down_counter_7bit;

  logic       clk;
  logic       reset;
  logic [6:0] q;

  int tests = 0;
  int fails = 0;

  // Model: number of rising edges seen since reset was last released.
  int n = 0;
  int prev_q = -1;

  down_counter_7bit dut (
    .clk   (clk),
    .reset (reset),
    .q     (q)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  function automatic int model_q();
    if (reset) return 127;
    return 127 - (n % 128);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    tests++;
    if ($isunknown(q)) begin
      fails++;
      $display("FAIL q_known at %0t: got %b, expected no X/Z", $time, q);
    end else begin
      check("model", int'(q), model_q());
      if (prev_q >= 0 && !reset) begin
        if (int'(q) != 127) check("step", int'(q), (prev_q + 127) % 128);
      end
      prev_q = int'(q);
    end
  end

  task automatic at(input time t);
    #(t - $time);
  endtask

  initial begin
    reset = 1'b1;
    at(1);    check("reset_immediate", int'(q), 127);
    at(11);   check("edge_in_reset",   int'(q), 127);
    at(15);   reset = 1'b0;
    at(31);   check("first_after_release",  int'(q), 126);
    at(51);   check("second_after_release", int'(q), 125);
    at(315);  check("after_15_edges", int'(q), 112);
    at(2551); check("reaches_zero",   int'(q), 0);
    at(2571); check("wrap_to_127",    int'(q), 127);
    at(2591); check("after_wrap",     int'(q), 126);
    at(3124); check("before_mid_reset", int'(q), 100);
    at(3125); reset = 1'b1;
    #1;       check("mid_reset_async", int'(q), 127);
    at(3171); check("held_in_reset",   int'(q), 127);
    at(3175); reset = 1'b0;
    at(3176); check("release_no_edge", int'(q), 127);
    at(3191); check("release_edge1", int'(q), 126);
    at(3211); check("release_edge2", int'(q), 125);
    at(3231); check("release_edge3", int'(q), 124);
    at(3300);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_down_counter_7bit
